// File: rtl/ubc_break_match.sv
// ubc_break_match: user-break condition engine.
// Evaluates channel A/B break conditions against the bus monitor and the
// instruction stream. It pulses compare-match flags back to the register
// block and raises the user-break request toward the interrupt controller.
//
// Sequential-mode FSM:
//   state      | meaning
//   ARMED_IDLE | waiting for a channel A match (sequential mode) or SEQ=0
//   A_HIT      | channel A matched; the next channel B match raises the break
module ubc_break_match #(
    parameter bit NONE_ON_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        RES_N,
    input  logic [31:0] BAR_A,
    input  logic [31:0] BAMR_A,
    input  logic [7:0]  BBR_A,
    input  logic [31:0] BAR_B,
    input  logic [31:0] BAMR_B,
    input  logic [7:0]  BBR_B,
    input  logic [31:0] BDR_B,
    input  logic [31:0] BDMR_B,
    input  logic        SEQ,
    input  logic        DBEB,
    input  logic        PCBA,
    input  logic        PCBB,
    input  logic        MON_VALID,
    input  logic [31:0] MON_A,
    input  logic [31:0] MON_D,
    input  logic        MON_CPU,
    input  logic        MON_WR,
    input  logic [1:0]  MON_SZ,
    input  logic        DEC_VALID,
    input  logic [31:0] DEC_PC,
    input  logic        EXE_DONE,
    input  logic        BRK_ACK,
    output logic        CMFA_SET,
    output logic        CMFB_SET,
    output logic        BRK_REQ,
    output logic        BRK_PRE
);

    typedef enum logic [0:0] {
        ARMED_IDLE = 1'b0,
        A_HIT      = 1'b1
    } seq_state_t;

    seq_state_t state, state_d;

    logic cmfa_q, cmfb_q, brk_req_q, brk_pre_q, pend_q;
    logic brk_req_d, brk_pre_d, pend_d;

    logic fa, da, fb, db;
    logic pre_req, post_arm, data_req, post_fire, new_req, hold, fin;
    logic [31:0] szmask;

    // Two-bit select field: bit0/bit1 pick the two classes, 00 means off (or don't-care)
    function automatic logic fld_ok(input logic [1:0] f, input logic sel);
        if (f == 2'b00) return !NONE_ON_ZERO;
        return sel ? f[1] : f[0];
    endfunction

    // SZ field: 00 any size, otherwise must equal bus size + 1
    function automatic logic sz_ok(input logic [1:0] f, input logic [1:0] sz);
        return (f == 2'b00) || (f == (sz + 2'd1));
    endfunction

    function automatic logic addr_ok(input logic [31:0] a, input logic [31:0] bar,
                                     input logic [31:0] bamr);
        return ((a ^ bar) & ~bamr) == 32'd0;
    endfunction

    // Raw per-channel matches: fetch class (CPU word read) and data class
    always_comb begin
        szmask = 32'hFFFF_FFFF;
        case (MON_SZ)
            2'd0:    szmask = 32'h0000_00FF;
            2'd1:    szmask = 32'h0000_FFFF;
            default: szmask = 32'hFFFF_FFFF;
        endcase

        fa = DEC_VALID && fld_ok(BBR_A[7:6], 1'b0) && fld_ok(BBR_A[5:4], 1'b0)
             && fld_ok(BBR_A[3:2], 1'b0) && sz_ok(BBR_A[1:0], 2'd1)
             && addr_ok(DEC_PC, BAR_A, BAMR_A);
        da = MON_VALID && fld_ok(BBR_A[7:6], !MON_CPU) && fld_ok(BBR_A[5:4], 1'b1)
             && fld_ok(BBR_A[3:2], MON_WR) && sz_ok(BBR_A[1:0], MON_SZ)
             && addr_ok(MON_A, BAR_A, BAMR_A);
        fb = DEC_VALID && fld_ok(BBR_B[7:6], 1'b0) && fld_ok(BBR_B[5:4], 1'b0)
             && fld_ok(BBR_B[3:2], 1'b0) && sz_ok(BBR_B[1:0], 2'd1)
             && addr_ok(DEC_PC, BAR_B, BAMR_B);
        db = MON_VALID && fld_ok(BBR_B[7:6], !MON_CPU) && fld_ok(BBR_B[5:4], 1'b1)
             && fld_ok(BBR_B[3:2], MON_WR) && sz_ok(BBR_B[1:0], MON_SZ)
             && addr_ok(MON_A, BAR_B, BAMR_B)
             && (!DBEB || (((MON_D ^ BDR_B) & ~BDMR_B & szmask) == 32'd0));
    end

    // Break decision, sequencing FSM next state and request/pending next values
    always_comb begin
        state_d  = state;
        pre_req  = 1'b0;
        post_arm = 1'b0;
        data_req = 1'b0;
        fin      = 1'b0;

        if (!SEQ) begin
            state_d  = ARMED_IDLE;
            pre_req  = (fa && !PCBA) || (fb && !PCBB);
            post_arm = (fa && PCBA) || (fb && PCBB);
            data_req = da || db;
        end else begin
            case (state)
                ARMED_IDLE: if (fa || da) state_d = A_HIT;
                A_HIT: begin
                    if (fb || db) begin
                        state_d = ARMED_IDLE;
                        fin     = 1'b1;
                    end
                end
                default: state_d = ARMED_IDLE;
            endcase
            // The final break in sequential mode follows channel B's PC-break timing
            pre_req  = fin && fb && !PCBB;
            post_arm = fin && fb && PCBB;
            data_req = fin && db;
        end

        post_fire = pend_q && EXE_DONE;
        new_req   = pre_req || data_req || post_fire;
        hold      = brk_req_q && !BRK_ACK;
        brk_req_d = new_req || hold;
        // A pre-exec request in flight keeps BRK_PRE set while further requests merge
        brk_pre_d = pre_req || (hold && brk_pre_q);

        // A newer pre-exec break supersedes any post-exec break still waiting
        if (pre_req)        pend_d = 1'b0;
        else if (post_arm)  pend_d = 1'b1;
        else if (post_fire) pend_d = 1'b0;
        else                pend_d = pend_q;
    end

    // Sequencing FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= ARMED_IDLE;
        else if (CE_R) begin
            if (!RES_N) state <= ARMED_IDLE;
            else        state <= state_d;
        end
    end

    // Registered match flags, break request and post-exec pending
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmfa_q    <= 1'b0;
            cmfb_q    <= 1'b0;
            brk_req_q <= 1'b0;
            brk_pre_q <= 1'b0;
            pend_q    <= 1'b0;
        end else if (CE_R) begin
            if (!RES_N) begin
                cmfa_q    <= 1'b0;
                cmfb_q    <= 1'b0;
                brk_req_q <= 1'b0;
                brk_pre_q <= 1'b0;
                pend_q    <= 1'b0;
            end else begin
                cmfa_q    <= fa || da;
                cmfb_q    <= fb || db;
                brk_req_q <= brk_req_d;
                brk_pre_q <= brk_pre_d;
                pend_q    <= pend_d;
            end
        end
    end

    assign CMFA_SET = cmfa_q;
    assign CMFB_SET = cmfb_q;
    assign BRK_REQ  = brk_req_q;
    assign BRK_PRE  = brk_pre_q;

endmodule

// File: tb/tb_ubc_break_match.sv
// Directed bench for ubc_break_match with hand-computed expectations.
module tb_ubc_break_match;

    logic        CLK = 1'b0;
    logic        RST_N, CE_R, RES_N;
    logic [31:0] BAR_A, BAMR_A, BAR_B, BAMR_B, BDR_B, BDMR_B;
    logic [7:0]  BBR_A, BBR_B;
    logic        SEQ, DBEB, PCBA, PCBB;
    logic        MON_VALID, MON_CPU, MON_WR;
    logic [31:0] MON_A, MON_D;
    logic [1:0]  MON_SZ;
    logic        DEC_VALID, EXE_DONE, BRK_ACK;
    logic [31:0] DEC_PC;
    logic        CMFA_SET, CMFB_SET, BRK_REQ, BRK_PRE;

    int n_vec = 0;
    int n_err = 0;

    ubc_break_match dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .RES_N(RES_N),
        .BAR_A(BAR_A), .BAMR_A(BAMR_A), .BBR_A(BBR_A),
        .BAR_B(BAR_B), .BAMR_B(BAMR_B), .BBR_B(BBR_B),
        .BDR_B(BDR_B), .BDMR_B(BDMR_B),
        .SEQ(SEQ), .DBEB(DBEB), .PCBA(PCBA), .PCBB(PCBB),
        .MON_VALID(MON_VALID), .MON_A(MON_A), .MON_D(MON_D), .MON_CPU(MON_CPU),
        .MON_WR(MON_WR), .MON_SZ(MON_SZ),
        .DEC_VALID(DEC_VALID), .DEC_PC(DEC_PC), .EXE_DONE(EXE_DONE), .BRK_ACK(BRK_ACK),
        .CMFA_SET(CMFA_SET), .CMFB_SET(CMFB_SET), .BRK_REQ(BRK_REQ), .BRK_PRE(BRK_PRE)
    );

    // 100 MHz system clock
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic cpu,
                       input logic wr, input logic [1:0] sz);
        MON_VALID = 1'b1; MON_A = a; MON_D = d; MON_CPU = cpu; MON_WR = wr; MON_SZ = sz;
        step();
        MON_VALID = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        DEC_VALID = 1'b1; DEC_PC = pc;
        step();
        DEC_VALID = 1'b0;
    endtask

    task automatic ack();
        BRK_ACK = 1'b1;
        step();
        BRK_ACK = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; CE_R = 1'b1; RES_N = 1'b1;
        BAR_A = '0; BAMR_A = '0; BBR_A = '0; BAR_B = '0; BAMR_B = '0; BBR_B = '0;
        BDR_B = '0; BDMR_B = '0; SEQ = 0; DBEB = 0; PCBA = 0; PCBB = 0;
        MON_VALID = 0; MON_A = '0; MON_D = '0; MON_CPU = 0; MON_WR = 0; MON_SZ = '0;
        DEC_VALID = 0; DEC_PC = '0; EXE_DONE = 0; BRK_ACK = 0;
        #22;
        chk("rst_cmfa", CMFA_SET, 0);
        chk("rst_cmfb", CMFB_SET, 0);
        chk("rst_req",  BRK_REQ,  0);
        chk("rst_pre",  BRK_PRE,  0);
        RST_N = 1'b1;
        step();

        // Channel A data address break
        BAR_A = 32'h0600_0100; BAMR_A = '0; BBR_A = 8'b11_10_10_00;
        bus(32'h0600_0100, 32'h1234, 1, 1, 2);
        chk("a_cmfa", CMFA_SET, 1);
        chk("a_cmfb", CMFB_SET, 0);
        chk("a_req",  BRK_REQ,  1);
        chk("a_pre",  BRK_PRE,  0);
        step();
        chk("a_cmfa_pulse", CMFA_SET, 0);
        chk("a_req_hold",   BRK_REQ,  1);
        ack();
        chk("a_req_ack", BRK_REQ, 0);

        // Masked address, read-only
        BAMR_A = 32'h0000_00FF; BBR_A = 8'b11_10_01_00;
        bus(32'h0600_01FE, 0, 1, 0, 1);
        chk("mask_hit", CMFA_SET, 1);
        BRK_ACK = 1'b1;
        bus(32'h0600_0200, 0, 1, 0, 1);
        BRK_ACK = 1'b0;
        chk("mask_miss", CMFA_SET, 0);
        chk("mask_ack",  BRK_REQ,  0);

        // Channel B masked data compare, channel A disabled via CP/ID/RW = 00
        BBR_A = 8'h00; BAMR_A = '0;
        BAR_B = 32'h0600_0400; BAMR_B = '0; BBR_B = 8'b01_10_10_01;
        DBEB = 1; BDR_B = 32'h0000_00AB; BDMR_B = 32'h0000_000F;
        bus(32'h0600_0400, 32'hA5, 1, 1, 0);
        chk("b_hit_cmfb", CMFB_SET, 1);
        chk("b_hit_cmfa", CMFA_SET, 0);
        chk("b_hit_req",  BRK_REQ,  1);
        chk("b_hit_pre",  BRK_PRE,  0);
        ack();
        bus(32'h0600_0400, 32'hB5, 1, 1, 0);
        chk("b_data_miss", CMFB_SET, 0);
        chk("b_data_req",  BRK_REQ,  0);
        bus(32'h0600_0400, 32'hA5, 1, 1, 1);
        chk("b_size_miss", CMFB_SET, 0);
        bus(32'h0600_0400, 32'hA5, 0, 1, 0);
        chk("b_periph_miss", CMFB_SET, 0);

        // Sequential A then B
        SEQ = 1; BAR_A = 32'h0600_0100; BBR_A = 8'b11_10_11_00;
        bus(32'h0600_0400, 32'hA5, 1, 1, 0);
        chk("seq_bfirst_cmfb", CMFB_SET, 1);
        chk("seq_bfirst_req",  BRK_REQ,  0);
        bus(32'h0600_0100, 32'h0, 1, 1, 2);
        chk("seq_a_cmfa", CMFA_SET, 1);
        chk("seq_a_req",  BRK_REQ,  0);
        bus(32'h0600_0400, 32'hA5, 1, 1, 0);
        chk("seq_b_cmfb", CMFB_SET, 1);
        chk("seq_b_req",  BRK_REQ,  1);
        ack();
        chk("seq_ack", BRK_REQ, 0);
        BAR_A = 32'h0600_0400;
        bus(32'h0600_0400, 32'hA5, 1, 1, 0);
        chk("seq_ab_cmfa", CMFA_SET, 1);
        chk("seq_ab_cmfb", CMFB_SET, 1);
        chk("seq_ab_req",  BRK_REQ,  0);
        bus(32'h0600_0400, 32'hA5, 1, 1, 0);
        chk("seq_ab2_req", BRK_REQ, 1);
        ack();
        SEQ = 0;

        // PC breaks on channel A, channel B off
        BBR_B = 8'h00; DBEB = 0;
        BAR_A = 32'h0000_1000; BAMR_A = '0; BBR_A = 8'b01_01_01_00; PCBA = 0;
        fetch(32'h0000_1000);
        chk("pc_pre_cmfa", CMFA_SET, 1);
        chk("pc_pre_req",  BRK_REQ,  1);
        chk("pc_pre_pre",  BRK_PRE,  1);
        ack();
        chk("pc_pre_ack", BRK_REQ, 0);
        PCBA = 1;
        fetch(32'h0000_1000);
        chk("pc_post_cmfa", CMFA_SET, 1);
        chk("pc_post_wait", BRK_REQ,  0);
        for (int i = 0; i < 3; i++) step();
        chk("pc_post_gap", BRK_REQ, 0);
        EXE_DONE = 1; step(); EXE_DONE = 0;
        chk("pc_post_req", BRK_REQ, 1);
        chk("pc_post_pre", BRK_PRE, 0);
        ack();

        // Pending post-exec break discarded by a newer pre-exec break
        fetch(32'h0000_1000);
        PCBA = 0;
        fetch(32'h0000_1000);
        chk("supersede_req", BRK_REQ, 1);
        chk("supersede_pre", BRK_PRE, 1);
        ack();
        EXE_DONE = 1; step(); EXE_DONE = 0;
        chk("supersede_drop", BRK_REQ, 0);

        // Pre-exec and data break together: BRK_PRE wins
        BBR_B = 8'b01_10_10_01; DBEB = 1;
        MON_VALID = 1; MON_A = 32'h0600_0400; MON_D = 32'hA5; MON_CPU = 1; MON_WR = 1; MON_SZ = 0;
        fetch(32'h0000_1000);
        MON_VALID = 0;
        chk("both_cmfb", CMFB_SET, 1);
        chk("both_req",  BRK_REQ,  1);
        chk("both_pre",  BRK_PRE,  1);
        ack();

        // Soft reset while pending and in A_HIT
        SEQ = 1; DBEB = 0; PCBB = 1;
        BAR_A = 32'h0600_0100; BBR_A = 8'b11_10_10_00;
        BAR_B = 32'h0000_2000; BAMR_B = '0; BBR_B = 8'b01_01_01_00;
        bus(32'h0600_0100, 0, 1, 1, 2);
        fetch(32'h0000_2000);
        chk("res_pend_cmfb", CMFB_SET, 1);
        chk("res_pend_req",  BRK_REQ,  0);
        bus(32'h0600_0100, 0, 1, 1, 2);
        RES_N = 0; step(); RES_N = 1;
        chk("res_cmfa", CMFA_SET, 0);
        chk("res_req",  BRK_REQ,  0);
        EXE_DONE = 1; step(); EXE_DONE = 0;
        chk("res_exe_req", BRK_REQ, 0);
        PCBB = 0;
        fetch(32'h0000_2000);
        chk("res_idle_cmfb", CMFB_SET, 1);
        chk("res_idle_req",  BRK_REQ,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ubc_break_match.md
Name: ubc_break_match

Overview:
- Break-condition engine that sits directly downstream of the UBC register block.
- Consumes channel A/B break registers (BAR/BAMR/BBR, BDR/BDMR, BRCR control bits) plus the CPU's bus-monitor and instruction-execution streams.
- Produces compare-match flag set pulses back to the register block and a user-break interrupt request to the interrupt controller.
- Supports independent A/B breaks, sequential A-then-B breaks, masked data compare on channel B, and PC breaks before or after execution.

Parameters:
- NONE_ON_ZERO, 1, when 1, a BBR CP/ID/RW field value of 00 disables the channel.

Ports:
- CLK  in  1  clock
- RST_N  in  1  async active-low reset
- CE_R  in  1  rising-phase clock enable; all state advances only when CE_R=1
- RES_N  in  1  synchronous soft reset (CPU reset pin), active-low
- BAR_A, BAMR_A  in  32 each  channel A address, address mask (1 = ignore bit)
- BBR_A  in  8  {CP[1:0],ID[1:0],RW[1:0],SZ[1:0]}
- BAR_B, BAMR_B  in  32 each  channel B address, address mask
- BBR_B  in  8  channel B cycle conditions, same layout as BBR_A
- BDR_B, BDMR_B  in  32 each  channel B data, data mask (1 = ignore bit)
- SEQ, DBEB, PCBA, PCBB  in  1 each  BRCR: sequential mode, data-break enable B, post-exec PC break A/B
- MON_VALID  in  1  bus data cycle completes this CE_R
- MON_A  in  32  bus address
- MON_D  in  32  bus data, right-justified by size
- MON_CPU  in  1  1 = CPU cycle, 0 = peripheral/DMA cycle
- MON_WR  in  1  1 = write
- MON_SZ  in  2  0 = byte, 1 = word, 2 = long
- DEC_VALID  in  1  instruction entering execute this CE_R
- DEC_PC  in  32  address of that instruction
- EXE_DONE  in  1  instruction issued by DEC_VALID has completed
- BRK_ACK  in  1  INTC accepted user break
- CMFA_SET, CMFB_SET  out  1 each  one-CE_R pulse: set CMF flag A/B
- BRK_REQ  out  1  user-break request level to INTC
- BRK_PRE  out  1  with BRK_REQ: break taken before execution (1) or after (0)

Behaviour:
- Reset (RST_N=0 or RES_N=0 on CE_R): all outputs 0, FSM ARMED_IDLE, pending post-exec cleared.
- Address match: ((A ^ BAR) & ~BAMR) == 0, all 32 bits.
- Cycle-class match:
  - CP: 01 CPU only, 10 peripheral only, 11 both.
  - ID: 01 fetch, 10 data, 11 both.
  - RW: 01 read, 10 write, 11 both.
  - SZ: 00 = any size, 01/10/11 = byte/word/long (MON_SZ+1).
  - CP, ID or RW equal to 00 disables the channel.
- Fetch-class match uses DEC_VALID/DEC_PC and treats the access as a CPU read of size word. Fetch matches on non-executed prefetches never occur.
- Data-class match uses MON_VALID with MON_A/MON_CPU/MON_WR/MON_SZ.
- Channel B data compare:
  - Applies only when DBEB=1, on data cycles.
  - Requires ((MON_D ^ BDR_B) & ~BDMR_B & szmask) == 0.
  - szmask is 000000FF for byte, 0000FFFF for word, FFFFFFFF for long.
- Match registering: raw matches are registered. CMFx_SET pulses exactly one CE_R after the matching cycle, whether or not a break is raised.
- Break decision, SEQ=0: any A or B match requests a break.
- Break decision, SEQ=1, FSM ARMED_IDLE -> A_HIT:
  - Transition on an A match.
  - A B match in ARMED_IDLE is ignored, but CMFB still pulses.
  - A and B matching in the same cycle only arms.
- Break decision, SEQ=1, FSM A_HIT -> ARMED_IDLE:
  - Transition on a B match, which requests a break.
  - A repeated A match stays in A_HIT.
- SEQ deasserted forces ARMED_IDLE.
- Timing of BRK_REQ:
  - Data break: asserts one CE_R after the match cycle, BRK_PRE=0.
  - Fetch break with PCBx=0: asserts one CE_R after DEC_VALID, BRK_PRE=1.
  - Fetch break with PCBx=1: latched pending; BRK_REQ asserts one CE_R after EXE_DONE, BRK_PRE=0.
- In sequential mode, PCBB governs the final break.
- BRK_REQ holds until BRK_ACK, deasserting the following CE_R.
- Further requests while BRK_REQ=1 merge (not queued).
- A request coincident with BRK_ACK re-asserts next cycle.
- Simultaneous pre-exec and data requests: BRK_PRE=1 wins.
- A pending post-exec break plus a newer pre-exec break: pre-exec issues, pending is discarded.
- Register inputs are sampled live every cycle. A register change during A_HIT does not disarm.

Test Plan:
- Channel A address break, BAR_A=0x06000100, BAMR_A=0, BBR_A=0b11_10_10_00; CPU write to 0x06000100 -> CMFA_SET pulse and BRK_REQ=1, BRK_PRE=0 on the next CE_R. BRK_REQ clears one cycle after BRK_ACK.
- Masked address, BAMR_A=0x000000FF, BAR_A=0x06000100; read 0x060001FE hits; read 0x06000200 -> no CMFA_SET.
- Channel B data break, DBEB=1, BDR_B=0x000000AB, BDMR_B=0x0F, BBR_B=0b01_10_10_01:
  - Byte write data 0xA5 -> CMFB_SET and BRK_REQ.
  - Data 0xB5 -> none.
  - Word write -> none (size mismatch).
- Sequential, SEQ=1:
  - B hit first -> CMFB_SET only, no BRK_REQ.
  - Then A hit, then B hit -> BRK_REQ on the B hit +1.
  - Same-cycle A+B hit -> arm only.
- PC break, BBR_A=0b01_01_01_00, DEC_PC=0x00001000:
  - PCBA=0 -> BRK_REQ, BRK_PRE=1 one CE_R after DEC_VALID.
  - PCBA=1 -> BRK_REQ, BRK_PRE=0 only after EXE_DONE, even with a 3-cycle gap.
- RES_N low while post-exec pending and in A_HIT -> BRK_REQ stays 0 after EXE_DONE; FSM back to idle (a B hit alone gives no break).
